// File: rtl/uart_pkg.sv
// Shared UART definitions: default line parameters, baud divisor helper, receiver states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    // Defaults shared by the transmitter and the receiver.
    localparam int unsigned CLK_FREQ_DEF  = 50_000_000;
    localparam int unsigned BAUD_RATE_DEF = 115200;
    localparam int unsigned WIDTH_DEF     = 8;

    // System clocks per line bit.
    function automatic int unsigned baud_period(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is a parameter.
// Latency: 2 clk cycles from d_i to q_o.
// Backpressure: none; free-running.
// Ports: clk, rst (sync, active-low), d_i (async input), q_o (synchronized output).
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, finds the start bit, samples each bit at mid-bit.
// Latency: data_valid one cycle after the mid-stop sample (~(WIDTH+1.5)*BAUD_PERIOD+3 cycles from start edge).
// Backpressure: none; data_valid/frame_err are single-cycle strobes the host must take when shown.
// Ports: clk, rst (sync, active-low), rx (async line, idles high), data, data_valid, frame_err, rx_busy.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = CLK_FREQ_DEF,
    parameter int unsigned BAUD_RATE = BAUD_RATE_DEF,
    parameter int unsigned WIDTH     = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             frame_err,
    output logic             rx_busy
);

    localparam int unsigned BAUD_PERIOD = baud_period(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF_PERIOD = BAUD_PERIOD / 2;
    localparam int unsigned CW          = $clog2(BAUD_PERIOD);
    localparam int unsigned BW          = $clog2(WIDTH) + 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_PERIOD - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    logic             rx_s;
    rx_state_t        state_q, state_d;
    logic [CW-1:0]    clk_c_q, clk_c_d;
    logic [BW-1:0]    bit_c_q, bit_c_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic             ferr_q,  ferr_d;

    uart_rx_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            clk_c_q <= '0;
            bit_c_q <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clk_c_q <= clk_c_d;
            bit_c_q <= bit_c_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clk_c_d = clk_c_q;
        bit_c_d = bit_c_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    clk_c_d = '0;
                end
            end
            START: begin
                if (clk_c_q == HALF_LAST) begin
                    clk_c_d = '0;
                    bit_c_d = '0;
                    // A start bit that is gone by mid-bit was noise.
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    clk_c_d = clk_c_q + 1'b1;
                end
            end
            DATA: begin
                if (clk_c_q == BAUD_LAST) begin
                    clk_c_d = '0;
                    // LSB arrives first, so shifting right leaves it in bit 0.
                    shift_d = {rx_s, shift_q[WIDTH-1:1]};
                    bit_c_d = bit_c_q + 1'b1;
                    if (bit_c_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    clk_c_d = clk_c_q + 1'b1;
                end
            end
            STOP: begin
                if (clk_c_q == BAUD_LAST) begin
                    clk_c_d = '0;
                    // Leaving at mid-stop gives half a bit of margin for a zero-gap next start.
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    clk_c_d = clk_c_q + 1'b1;
                end
            end
            BREAK: begin
                // A held-low line must not be mistaken for a fresh start bit.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign rx_busy    = (state_q != IDLE);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst) begin
            assert (!(data_valid && frame_err))
                else $error("uart_rx: data_valid and frame_err together");
            assert (bit_c_q <= BW'(WIDTH))
                else $error("uart_rx: bit counter out of range");
            assert (rx_busy || (state_q == IDLE))
                else $error("uart_rx: rx_busy low outside IDLE");
        end
    end
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's UART transmitter. It shares that block's CLK_FREQ, BAUD_RATE and WIDTH parameters.
- Takes the asynchronous serial line, synchronizes it, detects the start bit, and samples each bit at mid-bit.
- Presents each good frame as a parallel word with a one-cycle valid strobe. Flags framing errors.
- Sits between the FPGA pin and the host-side logic; in the loopback bench it is driven directly by the transmitter's tx output.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- WIDTH, 8, data bits per frame (LSB first).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-low (asserted when 0, sampled on posedge clk).
- rx  input  1  asynchronous serial line; idles high.
- data  output  WIDTH  last correctly received word.
- data_valid  output  1  one-cycle strobe; data is new this cycle.
- frame_err  output  1  one-cycle strobe; stop bit sampled low.
- rx_busy  output  1  high while a frame is in progress or the line is held in break.

Behaviour:
- Derived constants: BAUD_PERIOD = CLK_FREQ/BAUD_RATE (434 at defaults); HALF_PERIOD = BAUD_PERIOD/2 (217).
- clk_c width is $clog2(BAUD_PERIOD); bit_c width is $clog2(WIDTH)+1.
- Synchronizer: two flops on rx, reset to 1. All decisions use the second flop, rx_s.
- Reset (rst==0 at posedge): data=0, data_valid=0, frame_err=0, rx_busy=0, state=IDLE, counters=0, sync flops=1. Reset overrides everything, including a frame in progress; that frame is discarded with no strobe.
- IDLE:
  - rx_busy=0.
  - rx_s==0 -> START, clk_c=0.
- START:
  - Count clk_c to HALF_PERIOD-1, then sample rx_s.
  - If rx_s is 0 -> DATA, clk_c=0, bit_c=0.
  - If rx_s is 1, treat it as a glitch -> IDLE with no strobe.
- DATA:
  - Each time clk_c reaches BAUD_PERIOD-1: sample rx_s into the MSB of the shift register, shift right, bit_c+1, clk_c=0.
  - After the WIDTH-th sample -> STOP.
  - Result is LSB-first; the first data bit ends up in data[0].
- STOP:
  - At clk_c==BAUD_PERIOD-1, sample rx_s.
  - If 1: data <= shift register, data_valid=1 for exactly the next cycle -> IDLE.
  - If 0: frame_err=1 for exactly the next cycle, data is unchanged -> BREAK.
- BREAK:
  - Hold until rx_s==1, then -> IDLE.
  - No new start detection is made while held low.
- rx_busy is high in START, DATA, STOP and BREAK.
- data_valid and frame_err are never high in the same cycle, and each is never high for two consecutive cycles.
- Back-to-back frames: return to IDLE occurs at mid-stop, so a start edge arriving ≥ HALF_PERIOD later is detected. Zero inter-frame gap must work.
- Latency: data_valid rises 1 cycle after the mid-stop sample. That is about (WIDTH+1.5)×BAUD_PERIOD + 3 cycles after the rx falling edge (±2 cycles).
- No parity and no oversampling or majority vote (single mid-bit sample).
- Sim-only checks:
  - $error if data_valid && frame_err.
  - $error if bit_c > WIDTH.
  - $error if rx_busy==0 while state≠IDLE.

Decomposition:
- Package uart_pkg:
  - baud_period(clk_freq, baud_rate) constant function.
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK}.
  - Default parameter constants, shared with the transmitter.
- Sub-module uart_rx_sync: 2-flop synchronizer with reset value 1, parameterized reset level. It is reused by any future async inputs.

Test Plan:
- Reset then idle line high for 2000 cycles -> data=0x00, data_valid/frame_err never high, rx_busy=0.
- Send 0xA5 (line 0,1,0,1,0,0,1,0,1,1 at 434 cycles/bit) -> exactly one data_valid pulse about 4127 cycles after the start edge, data=0xA5, rx_busy falls the same cycle.
- rx low for 100 cycles then high -> no strobes; rx_busy high for about 219 cycles then 0; a following 0x3C frame is received correctly.
- After 0xA5, send 0x3C with stop bit low and hold rx low for 1000 cycles -> one frame_err pulse, data stays 0xA5, rx_busy stays 1 until rx returns high.
- Back-to-back 0x00 then 0xFF with zero gap -> two data_valid pulses 4340±2 cycles apart, data 0x00 then 0xFF.
- rst=0 for one cycle during data bit 4 of a frame -> all outputs 0 the next cycle, no strobe; the next frame 0x5A is received correctly. Loopback through the transmitter with 256 random words -> all match.
